// File: rtl/axis_red_pitaya_dac_fmt_if.sv
// Sample stream into the DAC formatter: one sample word carrying all channel lanes.
// A word moves on a cycle where tvalid and tready are both high. tready may rise without tvalid, and tdata is only looked at on that cycle.
interface axis_red_pitaya_dac_fmt_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_red_pitaya_dac_fmt.sv
// Multi-channel DAC formatter: rate-ticked sample intake, per-lane clip to DAC width,
// conversion to board DAC code, mute/hold on underrun and status reporting.
module axis_red_pitaya_dac_fmt #(
    parameter int NUM_CH           = 2,
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int RATE_WIDTH       = 16
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [RATE_WIDTH-1:0]              cfg_rate,
    input  logic                               cfg_mode,
    input  logic [NUM_CH-1:0]                  cfg_ch_en,
    axis_red_pitaya_dac_fmt_if.slave           s_axis,
    output logic [NUM_CH*DAC_DATA_WIDTH-1:0]   dac_dat,
    output logic                               dac_rst,
    output logic [1:0]                         sts_state,
    output logic [31:0]                        sts_underrun_cnt
);

    localparam int LANE_W = AXIS_TDATA_WIDTH / NUM_CH;
    localparam int DW     = DAC_DATA_WIDTH;

    localparam logic signed [SAMPLE_WIDTH-1:0] MAX_S = SAMPLE_WIDTH'(2**(DW-1) - 1);
    localparam logic signed [SAMPLE_WIDTH-1:0] MIN_S = SAMPLE_WIDTH'(-(2**(DW-1)));
    localparam logic [DW-1:0] MAX_DW    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_DW    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ZERO_CODE = {1'b0, {(DW-1){1'b1}}};
    localparam logic [NUM_CH*DW-1:0] ZERO_ALL = {NUM_CH{ZERO_CODE}};

    typedef enum logic [1:0] {
        ST_MUTE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [RATE_WIDTH-1:0]   cnt_q,      cnt_d;
    logic [31:0]             urun_q,     urun_d;
    logic [NUM_CH*DW-1:0]    stage1_q,   stage1_d;
    logic [NUM_CH*DW-1:0]    dac_q,      dac_d;
    logic                    dac_rst_q,  dac_rst_d;

    logic [RATE_WIDTH-1:0]   rate_m1;
    logic                    tick;
    logic [NUM_CH*DW-1:0]    conv;

    // A programmed rate of 0 behaves like 1 (a tick every cycle).
    assign rate_m1 = (cfg_rate == '0) ? '0 : cfg_rate - RATE_WIDTH'(1);
    assign tick    = (cnt_q == '0) && !areset;

    assign s_axis.tready = tick;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_conv
        logic signed [SAMPLE_WIDTH-1:0] s;
        logic [DW-1:0]                  c;
        assign s = s_axis.tdata[ch*LANE_W +: SAMPLE_WIDTH];
        assign c = (s > MAX_S) ? MAX_DW : (s < MIN_S) ? MIN_DW : s[DW-1:0];
        // Sign bit kept, magnitude bits inverted: the board DAC's offset code.
        assign conv[ch*DW +: DW] = {c[DW-1], ~c[DW-2:0]};
    end

    always_comb begin
        cnt_d     = (cnt_q >= rate_m1) ? '0 : cnt_q + RATE_WIDTH'(1);
        state_d   = state_q;
        urun_d    = urun_q;
        stage1_d  = stage1_q;
        dac_rst_d = (state_q == ST_MUTE);
        dac_d     = '0;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            dac_d[ch*DW +: DW] = cfg_ch_en[ch] ? stage1_q[ch*DW +: DW] : ZERO_CODE;
        end

        if (tick) begin
            if (s_axis.tvalid) begin
                state_d  = ST_RUN;
                stage1_d = conv;
            end else if (state_q != ST_MUTE) begin
                // A missing word only counts once the stream has started.
                state_d = ST_UNDERRUN;
                if (urun_q != '1) begin
                    urun_d = urun_q + 32'd1;
                end
                if (!cfg_mode) begin
                    stage1_d = ZERO_ALL;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_MUTE;
            cnt_q     <= '0;
            urun_q    <= '0;
            stage1_q  <= ZERO_ALL;
            dac_q     <= ZERO_ALL;
            dac_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            urun_q    <= urun_d;
            stage1_q  <= stage1_d;
            dac_q     <= dac_d;
            dac_rst_q <= dac_rst_d;
        end
    end

    assign dac_dat          = dac_q;
    assign dac_rst          = dac_rst_q;
    assign sts_state        = state_q;
    assign sts_underrun_cnt = urun_q;

endmodule

// File: tb/tb_axis_red_pitaya_dac_fmt.sv
// Bench for axis_red_pitaya_dac_fmt: a reference model queues the expected registered outputs,
// and a monitor compares them one cycle at a time; directed phases come first, then random traffic.
module tb_axis_red_pitaya_dac_fmt;

    localparam int NUM_CH = 2;
    localparam int DW     = 14;
    localparam int SW     = 16;
    localparam int TW     = 32;
    localparam int RW     = 16;
    localparam int EW     = NUM_CH*DW + 1 + 2 + 32;
    localparam int ZERO   = 2**(DW-1) - 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    areset;
    logic [RW-1:0]           cfg_rate;
    logic                    cfg_mode;
    logic [NUM_CH-1:0]       cfg_ch_en;
    logic [NUM_CH*DW-1:0]    dac_dat;
    logic                    dac_rst;
    logic [1:0]              sts_state;
    logic [31:0]             sts_underrun_cnt;

    axis_red_pitaya_dac_fmt_if #(.DATA_WIDTH(TW)) s_axis ();

    axis_red_pitaya_dac_fmt #(
        .NUM_CH(NUM_CH), .DAC_DATA_WIDTH(DW), .SAMPLE_WIDTH(SW),
        .AXIS_TDATA_WIDTH(TW), .RATE_WIDTH(RW)
    ) dut (
        .aclk(clk), .areset(areset), .cfg_rate(cfg_rate), .cfg_mode(cfg_mode),
        .cfg_ch_en(cfg_ch_en), .s_axis(s_axis), .dac_dat(dac_dat), .dac_rst(dac_rst),
        .sts_state(sts_state), .sts_underrun_cnt(sts_underrun_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // DAC code = inverted offset of the clipped value: full scale maps to 0, negative full scale to all ones.
    function automatic int to_code(input logic [SW-1:0] lane);
        int v;
        v = int'($signed(lane));
        if (v > ZERO) v = ZERO;
        if (v < -(ZERO + 1)) v = -(ZERO + 1);
        return ZERO - v;
    endfunction

    function automatic logic [SW-1:0] rand_lane();
        logic [SW-1:0] ext[6];
        ext = '{16'h7FFF, 16'h8000, 16'h1FFF, 16'hE000, 16'h2000, 16'hDFFF};
        case ($urandom_range(0, 3))
            0:       return SW'($urandom);
            1:       return SW'($urandom_range(0, 16383) - 8192);
            2:       return ext[$urandom_range(0, 5)];
            default: return SW'($urandom_range(0, 2) - 1);
        endcase
    endfunction

    // driver: inputs change on the falling edge
    task automatic cycle(input logic r, input logic v, input logic [TW-1:0] d);
        @(negedge clk);
        areset        = r;
        s_axis.tvalid = v;
        s_axis.tdata  = d;
    endtask

    // reference model: behaviour of the next rising edge, in terms of ticks and samples
    int          m_cnt = 0;
    int          m_state = 0;
    longint      m_ucnt = 0;
    int          m_s1[NUM_CH];
    int          m_dac[NUM_CH];
    logic        m_rst = 1'b1;

    always begin
        int rate;
        bit tick;
        logic [NUM_CH*DW-1:0] vec;
        @(negedge clk);
        #1;
        tick = !areset && (m_cnt == 0);
        check("tready", 32'(s_axis.tready), 32'(tick));
        if (areset) begin
            m_cnt = 0; m_state = 0; m_ucnt = 0; m_rst = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin m_s1[c] = ZERO; m_dac[c] = ZERO; end
        end else begin
            rate = (cfg_rate == 0) ? 1 : int'(cfg_rate);
            for (int c = 0; c < NUM_CH; c++) m_dac[c] = cfg_ch_en[c] ? m_s1[c] : ZERO;
            m_rst = (m_state == 0);
            if (tick) begin
                if (s_axis.tvalid) begin
                    m_state = 1;
                    for (int c = 0; c < NUM_CH; c++) m_s1[c] = to_code(s_axis.tdata[c*(TW/NUM_CH) +: SW]);
                end else if (m_state != 0) begin
                    m_state = 2;
                    if (m_ucnt < 64'hFFFF_FFFF) m_ucnt++;
                    if (!cfg_mode) for (int c = 0; c < NUM_CH; c++) m_s1[c] = ZERO;
                end
            end
            m_cnt = (m_cnt >= rate - 1) ? 0 : m_cnt + 1;
        end
        for (int c = 0; c < NUM_CH; c++) vec[c*DW +: DW] = DW'(m_dac[c]);
        exp_q.push_back({vec, m_rst, 2'(m_state), 32'(m_ucnt)});
    end

    // monitor: every rising edge produces one set of registered outputs
    always begin
        logic [EW-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < NUM_CH; c++)
                check($sformatf("dac_ch%0d", c), 32'(dac_dat[c*DW +: DW]), 32'(e[35 + c*DW +: DW]));
            check("dac_rst", 32'(dac_rst), 32'(e[34]));
            check("sts_state", 32'(sts_state), 32'(e[33:32]));
            check("underrun_cnt", sts_underrun_cnt, e[31:0]);
        end
    end

    task automatic spot(input string tag, input int st, input int rst, input int c0, input int c1, input int uc);
        @(posedge clk);
        #2;
        check({tag, "_state"}, 32'(sts_state), 32'(st));
        check({tag, "_rst"}, 32'(dac_rst), 32'(rst));
        check({tag, "_ch0"}, 32'(dac_dat[0 +: DW]), 32'(c0));
        check({tag, "_ch1"}, 32'(dac_dat[DW +: DW]), 32'(c1));
        check({tag, "_ucnt"}, sts_underrun_cnt, 32'(uc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; s_axis.tvalid = 1'b0; s_axis.tdata = '0;
        cfg_rate = 16'd1; cfg_mode = 1'b0; cfg_ch_en = 2'b11;

        repeat (3) cycle(1'b1, 1'b0, '0);
        spot("reset", 0, 1, 'h1FFF, 'h1FFF, 0);

        repeat (6) cycle(1'b0, 1'b1, 32'hFF9C_0064);
        spot("first", 1, 0, 'h1F9B, 'h2063, 0);

        repeat (4) cycle(1'b0, 1'b1, 32'h8000_7FFF);
        spot("sat_a", 1, 0, 'h0000, 'h3FFF, 0);
        repeat (4) cycle(1'b0, 1'b1, 32'h2000_DFFF);
        spot("sat_b", 1, 0, 'h3FFF, 'h0000, 0);

        cfg_rate = 16'd4;
        repeat (16) cycle(1'b0, 1'b1, $urandom);

        cfg_rate = 16'd1;
        repeat (3) cycle(1'b0, 1'b1, 32'hFF9C_0064);
        repeat (3) cycle(1'b0, 1'b0, $urandom);
        spot("urun_mute", 2, 0, 'h1FFF, 'h1FFF, 3);
        repeat (3) cycle(1'b0, 1'b1, 32'hFF9C_0064);
        spot("recover", 1, 0, 'h1F9B, 'h2063, 3);

        cfg_mode = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, $urandom);
        spot("urun_hold", 2, 0, 'h1F9B, 'h2063, 6);

        cfg_mode = 1'b0;
        repeat (4) cycle(1'b0, 1'b1, 32'h1234_0ABC);
        cfg_ch_en = 2'b01;
        repeat (3) cycle(1'b0, 1'b1, 32'h1234_0ABC);
        spot("ch1_off", 1, 0, to_code(16'h0ABC), 'h1FFF, 6);
        cfg_ch_en = 2'b11;
        repeat (2) cycle(1'b0, 1'b1, 32'h1234_0ABC);
        spot("ch1_on", 1, 0, to_code(16'h0ABC), to_code(16'h1234), 6);

        repeat (2) cycle(1'b0, 1'b1, 32'h4000_C000);
        cycle(1'b1, 1'b1, 32'h0100_0200);
        spot("mid_reset", 0, 1, 'h1FFF, 'h1FFF, 0);
        repeat (4) cycle(1'b0, 1'b1, 32'h0300_0400);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cfg_rate = RW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) cfg_mode = ~cfg_mode;
            if ($urandom_range(0, 39) == 0) cfg_ch_en = NUM_CH'($urandom_range(0, 3));
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, {rand_lane(), rand_lane()});
        end

        repeat (3) cycle(1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
